// File: rtl/case_sel_arbiter.sv
// case_sel_arbiter: round-robin arbiter sharing one 2-bit-select decoder among 4 requesters.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   request per requester, bit i belongs to requester i
//   done       granted requester finished (sampled only while busy)
//   gnt[3:0]   registered one-hot grant
//   sel[1:0]   binary index of the granted requester; holds last index when idle
//   sel_valid  high while sel addresses a granted requester
//   timeout    one-cycle pulse marking a forced release at the hold limit
module case_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StGap  = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  state_e           r_state;
  logic [3:0]       r_gnt;
  logic [1:0]       r_sel;
  logic             r_sel_valid;
  logic             r_timeout;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;

  logic [3:0] w_rot;
  logic [1:0] w_ofs;
  logic [1:0] w_winner;
  logic [3:0] w_onehot;
  logic       w_any;
  logic       w_exit_done;
  logic       w_exit_drop;
  logic       w_exit_lim;
  logic       w_exit;
  logic       w_timeout;

  // Rotate requests so bit 0 is the requester at ptr, then take the first set bit.
  // Any unknown request bit falls to the default arms, so the winner is always 2-state.
  always_comb begin
    w_rot = req;
    case (r_ptr)
      2'd0:    w_rot = req;
      2'd1:    w_rot = {req[0], req[3:1]};
      2'd2:    w_rot = {req[1:0], req[3:2]};
      2'd3:    w_rot = {req[2:0], req[3]};
      default: w_rot = 4'b0000;
    endcase

    w_ofs = 2'd0;
    casez (w_rot)
      4'b???1: w_ofs = 2'd0;
      4'b??10: w_ofs = 2'd1;
      4'b?100: w_ofs = 2'd2;
      4'b1000: w_ofs = 2'd3;
      default: w_ofs = 2'd0;
    endcase

    w_winner = r_ptr + w_ofs;

    w_onehot = 4'b0000;
    case (w_winner)
      2'd0:    w_onehot = 4'b0001;
      2'd1:    w_onehot = 4'b0010;
      2'd2:    w_onehot = 4'b0100;
      2'd3:    w_onehot = 4'b1000;
      default: w_onehot = 4'b0000;
    endcase

    w_any       = |req;
    w_exit_done = done;
    w_exit_drop = ~req[r_sel];
    w_exit_lim  = (r_hold_cnt == HoldLast);
    w_exit      = w_exit_done | w_exit_drop | w_exit_lim;
    // Limit coinciding with done or a dropped request counts as a normal release.
    w_timeout   = w_exit_lim & ~w_exit_done & ~w_exit_drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_gnt       <= 4'b0000;
      r_sel       <= 2'b00;
      r_sel_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_ptr       <= 2'b00;
      r_hold_cnt  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_state     <= StBusy;
            r_gnt       <= w_onehot;
            r_sel       <= w_winner;
            r_sel_valid <= 1'b1;
            r_hold_cnt  <= '0;
          end
        end
        StBusy: begin
          if (w_exit) begin
            r_state     <= StGap;
            r_gnt       <= 4'b0000;
            r_sel_valid <= 1'b0;
            r_ptr       <= r_sel + 2'd1;
            r_timeout   <= w_timeout;
          end else begin
            // Cannot wrap: the limit check forces exit before the counter overflows.
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        StGap: begin
          r_state   <= StIdle;
          r_timeout <= 1'b0;
        end
        default: begin
          r_state     <= StIdle;
          r_gnt       <= 4'b0000;
          r_sel       <= 2'b00;
          r_sel_valid <= 1'b0;
          r_timeout   <= 1'b0;
          r_ptr       <= 2'b00;
          r_hold_cnt  <= '0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign sel_valid = r_sel_valid;
  assign timeout   = r_timeout;

endmodule

// File: doc/case_sel_arbiter.md
Name: case_sel_arbiter

Overview:
- Round-robin arbiter that shares one 2-bit-select decoder resource among 4 requesters.
- Grants one requester at a time and drives the decoder select `sel` with the granted index.
- Holds the grant until the requester signals done, drops its request, or exceeds a hold limit.
- Guarantees `sel` is always a known 2-state value; it never carries X or Z into the decoder.

Parameters:
- MAX_HOLD, 8, maximum BUSY cycles per grant before forced release; legal range 1..2**CNT_W.
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i belongs to requester i.
- done  input  1  granted requester finished; sampled only in BUSY.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  binary index of the granted requester, drives the decoder select.
- sel_valid  output  1  high while `sel` addresses a granted requester.
- timeout  output  1  one-cycle pulse marking a forced release.

Behaviour:
- Reset (async, rst_n=0), effective immediately and regardless of state:
  - state=IDLE, gnt=4'b0000, sel=2'b00, sel_valid=0, timeout=0, ptr=2'b00, hold_cnt=0.
- States:
  - IDLE: no grant; evaluate req at each edge.
  - BUSY: grant active.
  - GAP: one-cycle dead time; decoder select settles.
  - Unused state encodings go to IDLE on the next edge, with all outputs at their reset values.
- Transitions:
  - IDLE -> BUSY: at an edge where req!=0.
    - Winner = first set bit searching ptr, ptr+1, ptr+2, ptr+3, all modulo 4.
    - After the edge: gnt=onehot(winner), sel=winner, sel_valid=1, hold_cnt=0.
    - Grant latency: 1 cycle from req sampled.
  - IDLE -> IDLE: req==0; outputs unchanged.
  - BUSY -> GAP: at an edge where any exit condition holds:
    - (a) done=1;
    - (b) req[sel]=0;
    - (c) hold_cnt==MAX_HOLD-1.
  - On BUSY -> GAP:
    - gnt=0, sel_valid=0.
    - ptr=sel+1 with 2-bit wrap, so 3 goes to 0.
    - timeout=1 only if (c) holds and neither (a) nor (b) holds.
  - BUSY -> BUSY: hold_cnt increments by 1; it never wraps, because (c) forces exit first.
  - GAP -> IDLE: unconditionally; timeout returns to 0.
- Grant duration: at most MAX_HOLD cycles.
- Spacing: minimum 2 cycles with gnt=0 between consecutive grants.
- sel hold rule: sel keeps the last granted index while sel_valid=0; it is never driven to X or Z.
- gnt is one-hot or zero at all times, and gnt==onehot(sel) whenever sel_valid=1.
- Changes to req bits other than req[sel] during BUSY have no effect.
- Simultaneous done and hold limit: treated as a normal release; timeout stays 0.
- Unknown inputs: an X/Z on req or done must not propagate to sel.
  - Every case statement has full coverage plus a default branch assigning known values.

Test Plan:
- Reset check: hold rst_n=0 -> gnt=0000, sel=00, sel_valid=0, timeout=0. Assert rst_n=0 mid-BUSY, asynchronously between edges -> outputs clear before the next edge.
- Single requester: req=0100 held, done pulsed on the 3rd BUSY cycle -> gnt=0100 and sel=10 one cycle after req. After the done edge: gnt=0000, sel stays 10, ptr=11.
- Rotation: req=1111 held, done pulsed every BUSY cycle -> grant order 0,1,2,3,0. 2 idle-grant cycles between grants; ptr wraps 3->0.
- Timeout: req=0001 held, done=0 -> BUSY lasts exactly 8 cycles. timeout=1 for the single GAP cycle, then requester 0 is re-granted (ptr=01, no others requesting).
- Simultaneous: done=1 on the 8th BUSY cycle (MAX_HOLD=8) -> release with timeout=0.
- Request drop: req=0010, then req[1] cleared on the 2nd BUSY cycle -> GAP next edge, timeout=0. req=1000 raised during BUSY is ignored until IDLE, then granted with sel=11.
